// File: rtl/fetch_to_decode.sv
// IF/ID pipeline register with a one-entry skid buffer, flush-to-bubble and
// saturating stall/flush performance counters.
module fetch_to_decode #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  ValidF,
    input  logic [DATA_WIDTH-1:0] InstrF,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  ReadyF,
    input  logic                  StallD,
    input  logic                  FlushD,
    output logic                  ValidD,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic [CNT_WIDTH-1:0]  StallCnt,
    output logic [CNT_WIDTH-1:0]  FlushCnt
);

    typedef enum logic [0:0] {SkidEmpty, SkidFull} skid_state_e;

    skid_state_e state_q, state_d;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pc4_q, pc4_d;

    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_pc4_q, skid_pc4_d;

    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q      <= SkidEmpty;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_q         <= '0;
            pc4_q        <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pc4_q        <= pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pc4_d        = pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;

        if (FlushD) begin
            // Squash everything in flight, including whatever fetch offers now.
            state_d = SkidEmpty;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = '0;
            pc4_d   = '0;
        end else if (StallD) begin
            if (state_q == SkidEmpty && ValidF) begin
                state_d      = SkidFull;
                skid_instr_d = InstrF;
                skid_pc_d    = PCF;
                skid_pc4_d   = PCPlus4F;
            end
        end else if (state_q == SkidFull) begin
            state_d = SkidEmpty;
            valid_d = 1'b1;
            instr_d = skid_instr_q;
            pc_d    = skid_pc_q;
            pc4_d   = skid_pc4_q;
        end else begin
            valid_d = ValidF;
            instr_d = ValidF ? InstrF : NOP_INSTR;
            pc_d    = PCF;
            pc4_d   = PCPlus4F;
        end
    end

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallD && valid_q && !FlushD && stall_cnt_q != {CNT_WIDTH{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (FlushD && flush_cnt_q != {CNT_WIDTH{1'b1}}) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    assign ReadyF   = (state_q == SkidEmpty);
    assign ValidD   = valid_q;
    assign InstrD   = instr_q;
    assign PCD      = pc_q;
    assign PCPlus4D = pc4_q;
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule
